// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory store buffer: width codes, entry layout
// and pointer sizing.
package dm_pkg;

  localparam logic [1:0] WIDTH_WORD = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } sb_entry_t;

  function automatic int depth_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dm_lane_gen.sv
// Maps an access (low address bits + width) onto DM byte lanes and replicates
// right-aligned data across the lanes it occupies.
module dm_lane_gen
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic        align_ok
);

  // Misaligned words and the reserved width code produce no lanes at all.
  always_comb begin
    be        = 4'b0000;
    lane_data = '0;
    align_ok  = 1'b0;
    case (width)
      WIDTH_WORD: begin
        align_ok  = (addr_lo == 2'b00);
        be        = align_ok ? 4'b1111 : 4'b0000;
        lane_data = data;
      end
      WIDTH_HALF: begin
        align_ok  = 1'b1;
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{data[15:0]}};
      end
      WIDTH_BYTE: begin
        align_ok  = 1'b1;
        be        = 4'b0001 << addr_lo;
        lane_data = {4{data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Store FIFO between MEM and the data memory: drains one store per idle DM
// cycle and forwards buffered bytes to loads, newest store winning.
module dm_store_buffer
  import dm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_width,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_width,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_pc,
  output logic        empty
);

  localparam int PTR_W = depth_bits(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [3:0]  st_be;
  logic [31:0] st_lane;
  logic        st_align_ok;
  logic [3:0]  ld_be;
  logic [31:0] ld_lane_unused;
  logic        ld_align_ok;

  dm_lane_gen u_st_lane (
    .addr_lo  (st_addr[1:0]),
    .width    (st_width),
    .data     (st_data),
    .be       (st_be),
    .lane_data(st_lane),
    .align_ok (st_align_ok)
  );

  dm_lane_gen u_ld_lane (
    .addr_lo  (ld_addr[1:0]),
    .width    (ld_width),
    .data     (32'd0),
    .be       (ld_be),
    .lane_data(ld_lane_unused),
    .align_ok (ld_align_ok)
  );

  logic push;
  logic drain_ok;

  // Full is judged on count alone, so a draining full buffer still refuses.
  assign st_ready = (count != FULL_COUNT);
  assign empty    = (count == '0);
  assign push     = st_valid && st_ready && st_align_ok;
  assign drain_ok = !empty && (!ld_valid || ld_stall);

  logic [31:0]      merge;
  logic [3:0]       covered;
  logic [PTR_W-1:0] idx;

  // Walk oldest to newest so later stores overwrite earlier bytes.
  always_comb begin
    merge   = '0;
    covered = 4'b0000;
    idx     = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (entries[idx].valid && (entries[idx].word_addr == ld_addr[31:2])) begin
        covered = covered | entries[idx].be;
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].be[b]) merge[8*b +: 8] = entries[idx].data[8*b +: 8];
        end
      end
    end
  end

  logic [3:0] need;
  assign need = (ld_valid && ld_align_ok) ? ld_be : 4'b0000;

  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    if ((covered & need) != 4'b0000) begin
      if ((covered & need) == need) begin
        ld_hit  = 1'b1;
        ld_data = merge;
      end else begin
        ld_stall = 1'b1;
      end
    end
  end

  sb_entry_t head_entry;
  assign head_entry = entries[head];
  assign dm_we   = drain_ok;
  assign dm_addr = head_entry.valid ? {head_entry.word_addr, 2'b00} : '0;
  assign dm_wd   = head_entry.valid ? head_entry.data : '0;
  assign dm_be   = head_entry.valid ? head_entry.be : 4'b0000;
  assign dm_pc   = head_entry.valid ? head_entry.pc : '0;

  // Popped entries are invalidated so the search never sees stale stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (push) begin
        entries[tail] <= '{valid: 1'b1, word_addr: st_addr[31:2], data: st_lane,
                           be: st_be, pc: st_pc};
        tail <= tail + 1'b1;
      end
      if (drain_ok) begin
        entries[head].valid <= 1'b0;
        head <= head + 1'b1;
      end
      case ({push, drain_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
